// File: rtl/fc_pkg.sv
// Shared constants and FSM encoding for the fully-connected MAC/bias/activation slice.
package fc_pkg;

    localparam int ACC_W_DEF  = 24;
    localparam int BIAS_W_DEF = 16;
    localparam int SHIFT_DEF  = 7;
    // Signed 8-bit weight times zero-extended 8-bit activation.
    localparam int PROD_W     = 17;
    localparam int BIAS_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_BIAS = 2'd1,
        ST_ACT  = 2'd2,
        ST_HOLD = 2'd3
    } fc_state_t;

endpackage

// File: rtl/fc_act_quant.sv
// ReLU, arithmetic right shift and clamp to 8-bit unsigned; purely combinational.
module fc_act_quant
    import fc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [7:0]       q
);

    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc >>> SHIFT;

    // NOTE: q gets a value on every path so no latch is inferred.
    always_comb begin
        q = '0;
        if (acc[ACC_W-1] || (acc == '0)) begin
            q = '0;
        end else if (|shifted[ACC_W-1:8]) begin
            q = 8'hFF;
        end else begin
            q = shifted[7:0];
        end
    end

endmodule

// File: rtl/fc_mac_bias_unit.sv
// Neuron MAC pipeline with bias add, ReLU/requantize and bias table.
// Optional saturating accumulator: define FC_MAC_ACC_SAT_EN.
module fc_mac_bias_unit
    import fc_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int BIAS_W = BIAS_W_DEF,
    parameter int SHIFT  = SHIFT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic signed [7:0]   weight_in,
    input  logic        [7:0]   data_in,
    output logic                mac_ready,
    input  logic                bias_valid,
    input  logic        [3:0]   bias_sel,
    output logic                bias_ready,
    output logic        [7:0]   al_result,
    input  logic                bias_wr_en,
    input  logic        [3:0]   bias_wr_addr,
    input  logic signed [BIAS_W-1:0] bias_wr_data,
    output logic                err
);

    fc_state_t state, state_nxt;

    logic accept_in, drop_in, do_bias, do_act;

    logic                     s1_valid;
    logic signed [7:0]        s1_w;
    logic        [7:0]        s1_d;
    logic                     s2_valid;
    logic signed [PROD_W-1:0] s2_prod;
    logic signed [PROD_W-1:0] w_ext, d_ext;

    logic signed [ACC_W-1:0]  acc, acc_sum, addend;
    logic signed [BIAS_W-1:0] bias_tab [BIAS_DEPTH];
    logic signed [BIAS_W-1:0] bias_rd;
    logic        [7:0]        quant_q;

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_ACC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_ACC:  if (bias_valid && !s1_valid && !s2_valid && !in_valid) state_nxt = ST_BIAS;
            ST_BIAS: state_nxt = ST_ACT;
            ST_ACT:  state_nxt = ST_HOLD;
            ST_HOLD: if (!bias_valid) state_nxt = ST_ACC;
            default: state_nxt = ST_ACC;
        endcase
    end

    always_comb begin
        do_bias   = (state == ST_BIAS);
        do_act    = (state == ST_ACT);
        drop_in   = in_valid && (do_bias || do_act);
        accept_in = in_valid && !(do_bias || do_act);
    end

    // ---------------- MAC pipeline ----------------
    assign w_ext = PROD_W'(s1_w);
    assign d_ext = PROD_W'({1'b0, s1_d});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_w      <= '0;
            s1_d      <= '0;
            s2_valid  <= 1'b0;
            s2_prod   <= '0;
            mac_ready <= 1'b0;
        end else begin
            s1_valid  <= accept_in;
            s1_w      <= weight_in;
            s1_d      <= data_in;
            s2_valid  <= s1_valid;
            s2_prod   <= w_ext * d_ext;
            mac_ready <= s2_valid;
        end
    end

    // ---------------- Bias table ----------------
    // NOTE: the table is reset explicitly, so it maps to flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BIAS_DEPTH; i++) bias_tab[i] <= '0;
        end else if (bias_wr_en) begin
            bias_tab[bias_wr_addr] <= bias_wr_data;
        end
    end

    // Read is combinational from the current contents, so a same-cycle write is not visible.
    assign bias_rd = bias_tab[bias_sel];

    // ---------------- Accumulator ----------------
    assign addend = do_bias ? ACC_W'(bias_rd) : ACC_W'(s2_prod);

`ifdef FC_MAC_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic signed [ACC_W:0] sum_ext;

    assign sum_ext = (ACC_W+1)'(acc) + (ACC_W+1)'(addend);

    always_comb begin
        acc_sum = sum_ext[ACC_W-1:0];
        if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
            acc_sum = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    assign acc_sum = acc + addend;
`endif

    // No product can be in flight during BIAS or ACT, so the priorities never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (do_act) begin
            acc <= '0;
        end else if (do_bias || s2_valid) begin
            acc <= acc_sum;
        end
    end

    // ---------------- Activation and outputs ----------------
    fc_act_quant #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_act_quant (
        .acc (acc),
        .q   (quant_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            al_result  <= '0;
            bias_ready <= 1'b0;
            err        <= 1'b0;
        end else begin
            bias_ready <= do_act;
            if (do_act)  al_result <= quant_q;
            if (drop_in) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fc_mac_bias_unit.sv
// Directed self-checking bench for fc_mac_bias_unit (default build, wrapping accumulator).
module tb_fc_mac_bias_unit;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic signed [7:0] weight_in;
    logic        [7:0] data_in;
    logic              mac_ready;
    logic              bias_valid;
    logic        [3:0] bias_sel;
    logic              bias_ready;
    logic        [7:0] al_result;
    logic              bias_wr_en;
    logic        [3:0] bias_wr_addr;
    logic signed [15:0] bias_wr_data;
    logic              err;

    int checks   = 0;
    int failures = 0;
    int mac_cnt  = 0;
    int br_cnt   = 0;
    int base_m, base_b;

    always #5 clk = ~clk;

    fc_mac_bias_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .weight_in    (weight_in),
        .data_in      (data_in),
        .mac_ready    (mac_ready),
        .bias_valid   (bias_valid),
        .bias_sel     (bias_sel),
        .bias_ready   (bias_ready),
        .al_result    (al_result),
        .bias_wr_en   (bias_wr_en),
        .bias_wr_addr (bias_wr_addr),
        .bias_wr_data (bias_wr_data),
        .err          (err)
    );

    // Pulses are counted on the edge after they appear; the stimulus reads counters on negedges.
    always @(posedge clk) begin
        if (mac_ready === 1'b1)  mac_cnt++;
        if (bias_ready === 1'b1) br_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_pairs(input logic signed [7:0] w, input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b1;
            weight_in = w;
            data_in   = d;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic write_bias(input logic [3:0] addr, input logic signed [15:0] data);
        bias_wr_en   = 1'b1;
        bias_wr_addr = addr;
        bias_wr_data = data;
        @(negedge clk);
        bias_wr_en   = 1'b0;
    endtask

    task automatic wait_bias_ready(input string tag, input logic [7:0] exp_al);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bias_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_bias_ready_seen"}, 32'(seen), 32'd1);
        check({tag, "_al_result"}, 32'(al_result), 32'(exp_al));
    endtask

    task automatic finish_neuron(input string tag, input logic [3:0] sel, input logic [7:0] exp_al);
        bias_valid = 1'b1;
        bias_sel   = sel;
        wait_bias_ready(tag, exp_al);
    endtask

    task automatic release_bias();
        bias_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        weight_in    = '0;
        data_in      = '0;
        bias_valid   = 1'b0;
        bias_sel     = '0;
        bias_wr_en   = 1'b0;
        bias_wr_addr = '0;
        bias_wr_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_al_result", 32'(al_result), 32'd0);
        check("rst_mac_ready", 32'(mac_ready), 32'd0);
        check("rst_bias_ready", 32'(bias_ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        write_bias(4'd0, 16'sd10);
        write_bias(4'd3, 16'sd1000);
        write_bias(4'd4, 16'sd256);

        // 25 * (2*3) + 10 = 160 -> 160 >>> 7 = 1
        base_m = mac_cnt; base_b = br_cnt;
        send_pairs(8'sd2, 8'd3, 25);
        finish_neuron("basic", 4'd0, 8'd1);
        release_bias();
        check("basic_mac_pulses", 32'(mac_cnt - base_m), 32'd25);
        check("basic_bias_pulses", 32'(br_cnt - base_b), 32'd1);

        // 4 * (-128*255) = -130560 -> ReLU 0
        base_m = mac_cnt;
        send_pairs(-8'sd128, 8'd255, 4);
        finish_neuron("relu", 4'd1, 8'd0);
        release_bias();
        check("relu_mac_pulses", 32'(mac_cnt - base_m), 32'd4);

        // 26 * 32385 + 1000 = 843010 -> 6586 -> clamp 255; then hold bias_valid 5 cycles
        base_b = br_cnt;
        send_pairs(8'sd127, 8'd255, 26);
        finish_neuron("clamp", 4'd3, 8'd255);
        base_m = mac_cnt;
        send_pairs(8'sd4, 8'd64, 2);
        repeat (3) @(negedge clk);
        check("hold_al_stable", 32'(al_result), 32'd255);
        check("hold_single_bias_ready", 32'(br_cnt - base_b), 32'd1);
        check("hold_mac_pulses", 32'(mac_cnt - base_m), 32'd2);
        release_bias();
        // Products from HOLD: 2 * 256 = 512 -> 4
        finish_neuron("hold_next", 4'd2, 8'd4);
        release_bias();
        check("err_still_clear", 32'(err), 32'd0);

        // Write to entry 4 during its BIAS cycle: old 256 -> 2, then new 1280 -> 10
        bias_valid = 1'b1;
        bias_sel   = 4'd4;
        @(negedge clk);
        write_bias(4'd4, 16'sd1280);
        wait_bias_ready("wr_collide", 8'd2);
        release_bias();
        finish_neuron("wr_new_value", 4'd4, 8'd10);
        release_bias();

        // in_valid in BIAS cycle is dropped and flags err; bias 1000 -> 7
        base_m = mac_cnt;
        bias_valid = 1'b1;
        bias_sel   = 4'd3;
        @(negedge clk);
        send_pairs(8'sd5, 8'd5, 1);
        wait_bias_ready("drop", 8'd7);
        release_bias();
        repeat (3) @(negedge clk);
        check("drop_no_mac", 32'(mac_cnt - base_m), 32'd0);
        check("drop_err_set", 32'(err), 32'd1);
        repeat (4) @(negedge clk);
        check("drop_err_sticky", 32'(err), 32'd1);

        // Reset with products in S1 and S2
        in_valid  = 1'b1;
        weight_in = 8'sd1;
        data_in   = 8'd1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        base_m   = mac_cnt;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_mac", 32'(mac_cnt - base_m), 32'd0);
        check("midrst_al_result", 32'(al_result), 32'd0);
        check("midrst_bias_ready", 32'(bias_ready), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        // Entry 4 held 1280 before reset; a cleared table yields 0
        finish_neuron("midrst_table", 4'd4, 8'd0);
        release_bias();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_mac_bias_unit.md
FC_MAC_BIAS_UNIT -- requirements
Module: fc_mac_bias_unit

Interface
REQ-001 SHALL have parameter ACC_W, 24, accumulator width in bits, signed.
REQ-002 SHALL have parameter BIAS_W, 16, bias table entry width, signed.
REQ-003 SHALL have parameter SHIFT, 7, requantization right-shift amount.
REQ-004 SHALL have port clk  in  1  clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  in  1  operand pair valid this cycle (driven by the controller's data_valid).
REQ-006 SHALL have port weight_in  in  8  signed weight; data_in  in  8  unsigned activation.
REQ-007 SHALL have port mac_ready  out  1  one-cycle pulse per product accumulated.
REQ-008 SHALL have port bias_valid  in  1  level request to finish the current neuron; bias_sel  in  4  bias table index.
REQ-009 SHALL have port bias_ready  out  1  one-cycle pulse when al_result is updated; al_result  out  8  unsigned activated neuron output.
REQ-010 SHALL have port bias_wr_en  in  1; bias_wr_addr  in  4; bias_wr_data  in  BIAS_W  bias table write port.
REQ-011 SHALL have port err  out  1  sticky protocol-error flag.

Function
REQ-012 SHALL implement a 3-stage MAC pipeline: S1 registers operands, S2 registers the 17-bit signed product weight_in*{0,data_in}, S3 adds the sign-extended product into acc.
REQ-013 SHALL assert mac_ready exactly in cycle t+2 for in_valid sampled at edge t, for exactly one cycle per product.
REQ-014 SHALL, without FC_MAC_ACC_SAT_EN, accumulate in two's complement with wrap-around at ACC_W bits.
REQ-015 SHALL run FSM states ACC, BIAS, ACT, HOLD; reset state ACC.
REQ-016 SHALL transition ACC->BIAS when bias_valid=1 and S1, S2 and in_valid are all 0; a product retiring in that cycle is accumulated first.
REQ-017 SHALL, in BIAS (one cycle), add bias table[bias_sel] sign-extended to ACC_W into acc; next state ACT.
REQ-018 SHALL, in ACT (one cycle), register al_result = 0 if acc<=0, else min(acc>>>SHIFT, 255), pulse bias_ready, clear acc; next state HOLD.
REQ-019 SHALL stay in HOLD while bias_valid=1, accumulating new products normally; HOLD->ACC when bias_valid=0; no second bias request is accepted until then.
REQ-020 SHALL drop any in_valid sampled in BIAS or ACT (no mac_ready for it) and set err; err is cleared only by reset.
REQ-021 SHALL write bias table entry bias_wr_addr on bias_wr_en at any state; a same-cycle write and BIAS read of the same entry returns the old value.
REQ-022 SHALL hold al_result stable between bias_ready pulses.

Reset
REQ-023 SHALL, on rst_n low, clear acc, pipeline valids, al_result, mac_ready, bias_ready, err and all 16 bias entries, and enter ACC.
REQ-024 SHALL discard any in-flight products on reset mid-operation; no mac_ready follows reset release for them.

Configuration
REQ-025 SHALL, with FC_MAC_ACC_SAT_EN defined, saturate acc at signed ACC_W max/min on both product and bias additions; without it, wrap per REQ-014.

Structure
REQ-026 SHALL place FSM state encoding, ACC_W/BIAS_W/SHIFT defaults and product width constant in shared package fc_pkg.
REQ-027 SHALL implement ReLU/shift/clamp as sub-module fc_act_quant (ACC_W in, 8 out, combinational), registered by the parent.

Verification
REQ-028 SHALL cover: 25 pairs weight=2,data=3, bias[0]=10, bias_valid sel=0 -> 25 mac_ready pulses, acc=160, al_result=1 (160>>>7), one bias_ready.
REQ-029 SHALL cover: weight=-128,data=255 x4, bias 0 -> al_result=0 (ReLU), bias_ready once.
REQ-030 SHALL cover: weight=127,data=255 x26, bias[3]=1000 -> al_result=255 (clamp); with FC_MAC_ACC_SAT_EN and ACC_W=16, acc pins at 32767.
REQ-031 SHALL cover: bias_valid held high 5 cycles after bias_ready -> exactly one bias_ready; products during HOLD accumulate into next neuron.
REQ-032 SHALL cover: in_valid pulsed in BIAS cycle -> no mac_ready for it, err=1 and stays 1.
REQ-033 SHALL cover: rst_n low with 2 products in S1/S2 -> no mac_ready after release, all outputs 0, bias table 0.
